// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler
// Round-robin burst scheduler that shares one registered valid/ready output
// between N_CH show-ahead FIFOs. Each grant pops up to MAX_BURST words from
// one channel, tagging every word with its source channel. Arbitration costs
// one idle cycle between grants and restarts from the channel after the last
// one served, so a continuously busy channel waits at most N_CH-1 grants.

module fifo_rr_scheduler #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_CH-1:0]         fifo_empty_i,
  input  logic [N_CH*WIDTH-1:0]   fifo_data_i,
  output logic [N_CH-1:0]         fifo_rd_en_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [$clog2(N_CH)-1:0] out_ch_o,
  output logic                    busy_o
);

  localparam int CH_W = $clog2(N_CH);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

  // Channel index arithmetic with explicit wrap so that a non-power-of-two
  // channel count never relies on natural counter overflow.
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                               input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_CH) begin
      return CH_W'(sum - N_CH);
    end else begin
      return CH_W'(sum);
    end
  endfunction

  logic [0:0]       state_r;
  logic [CH_W-1:0]  prio_ptr_r;
  logic [CH_W-1:0]  grant_r;
  logic [BC_W-1:0]  burst_cnt_r;

  logic             sel_valid_s;
  logic [CH_W-1:0]  sel_ch_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             can_load_s;
  logic             grant_empty_s;
  logic             burst_last_s;
  logic             pop_s;
  logic             exit_s;
  logic [CH_W-1:0]  next_ptr_s;

  // Pick the first non-empty channel searching upward from prio_ptr with wrap.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_ch_s    = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_ch_s    = (!sel_valid_s && !fifo_empty_i[wrap_add(prio_ptr_r, i)])
                    ? wrap_add(prio_ptr_r, i) : sel_ch_s;
      sel_valid_s = sel_valid_s | ~fifo_empty_i[wrap_add(prio_ptr_r, i)];
    end
  end

  // Select the granted channel's show-ahead word from the packed data bus.
  always_comb begin
    grant_data_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      grant_data_s = (grant_r == CH_W'(k)) ? fifo_data_i[k*WIDTH +: WIDTH]
                                           : grant_data_s;
    end
  end

  // Pop / burst-exit decisions for the channel currently holding the grant.
  always_comb begin
    can_load_s    = ~out_valid_o | out_ready_i;
    grant_empty_s = fifo_empty_i[grant_r];
    pop_s         = (state_r == ST_GRANT) & can_load_s & ~grant_empty_s;
    burst_last_s  = (burst_cnt_r == BURST_LAST);
    exit_s        = (state_r == ST_GRANT) & ((pop_s & burst_last_s) | grant_empty_s);
    next_ptr_s    = wrap_add(grant_r, 32'sd1);
  end

  // Read enable is one-hot on the granted channel, only when a pop happens,
  // so an empty FIFO is never read.
  always_comb begin
    fifo_rd_en_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      fifo_rd_en_o[k] = pop_s & (grant_r == CH_W'(k));
    end
  end

  assign busy_o = (state_r == ST_GRANT);

  // Arbitration FSM: one IDLE cycle to latch a grant, then a bounded burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      prio_ptr_r  <= '0;
      grant_r     <= '0;
      burst_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_valid_s) begin
            grant_r     <= sel_ch_s;
            burst_cnt_r <= '0;
            state_r     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (pop_s) begin
            burst_cnt_r <= burst_cnt_r + BC_W'(1);
          end
          if (exit_s) begin
            state_r    <= ST_IDLE;
            prio_ptr_r <= next_ptr_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Single-stage output register; refilled in the same cycle it is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
    end else if (pop_s) begin
      out_valid_o <= 1'b1;
      out_data_o  <= grant_data_s;
      out_ch_o    <= grant_r;
    end else if (out_valid_o & out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench for fifo_rr_scheduler: queue-based FIFO models feed the
// DUT, a cycle-level reference model derived from the scheduling rules predicts
// every output, and a per-channel scoreboard checks word order end to end.

module tb_fifo_rr_scheduler;

  localparam int N_CH      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int CH_W      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       fifo_empty;
  logic [N_CH*WIDTH-1:0] fifo_data;
  logic [N_CH-1:0]       rd_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  busy;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.N_CH(N_CH), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_en_o (rd_en),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_ch_o     (out_ch),
    .busy_o       (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] q     [N_CH][$];
  logic [WIDTH-1:0] exp_w [N_CH][$];

  bit               m_busy;
  bit               m_valid;
  int               m_ptr;
  int               m_grant;
  int               m_cnt;
  logic [WIDTH-1:0] m_data;
  int               m_ch;

  logic [N_CH-1:0]  rd_log   [$];
  int               cons_ch  [$];
  logic [WIDTH-1:0] cons_dat [$];

  logic [N_CH-1:0] exp_single [6]  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
  logic [N_CH-1:0] exp_pin    [6]  = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h1, 4'h0};
  logic [N_CH-1:0] exp_burst  [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1,
                                       4'h0, 4'h1, 4'h1, 4'h0, 4'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    for (int k = 0; k < N_CH; k++) begin
      fifo_empty[k] = (q[k].size() == 0);
      fifo_data[k*WIDTH +: WIDTH] = (q[k].size() != 0) ? q[k][0] : 8'hEE;
    end
  endtask

  task automatic push(input int ch, input logic [WIDTH-1:0] val);
    q[ch].push_back(val);
    exp_w[ch].push_back(val);
    drive_fifo();
  endtask

  task automatic clear_all();
    for (int k = 0; k < N_CH; k++) begin
      q[k].delete();
      exp_w[k].delete();
    end
    drive_fifo();
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_ptr   = 0;
    m_grant = 0;
    m_cnt   = 0;
    m_data  = '0;
    m_ch    = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, then let the
  // FIFO models apply the pops the DUT requested just after the rising edge.
  task automatic cycle();
    logic [N_CH-1:0] exp_rd;
    logic [N_CH-1:0] rd_now;
    bit can_load, nonempty, pop, leave, found;
    int g;
    @(negedge clk);
    if (!rst_n) model_reset();
    exp_rd   = '0;
    pop      = 1'b0;
    nonempty = 1'b0;
    leave    = 1'b0;
    g        = m_grant;
    can_load = !m_valid || out_ready;
    if (rst_n && m_busy) begin
      nonempty = (q[g].size() != 0);
      pop      = can_load && nonempty;
      if (pop) exp_rd[g] = 1'b1;
    end
    rd_now = rd_en;
    check("rd_en", rd_en, exp_rd);
    check("rd_on_empty", rd_en & fifo_empty, 0);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_ch", out_ch, m_ch);
    rd_log.push_back(rd_en);
    if (rst_n && out_valid && out_ready) begin
      cons_ch.push_back(int'(out_ch));
      cons_dat.push_back(out_data);
      if (exp_w[out_ch].size() == 0) begin
        check("scoreboard_extra_word", 1, 0);
      end else begin
        check("scoreboard_order", out_data, exp_w[out_ch].pop_front());
      end
    end
    if (rst_n) begin
      if (!m_busy) begin
        if (m_valid && out_ready) m_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          if (!found && q[(m_ptr + i) % N_CH].size() != 0) begin
            found   = 1'b1;
            m_grant = (m_ptr + i) % N_CH;
          end
        end
        if (found) begin
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end else begin
        if (pop) begin
          m_data  = q[g][0];
          m_ch    = g;
          m_valid = 1'b1;
          m_cnt++;
          if (m_cnt == MAX_BURST) leave = 1'b1;
        end else begin
          if (m_valid && out_ready) m_valid = 1'b0;
          if (!nonempty) leave = 1'b1;
        end
        if (leave) begin
          m_busy = 1'b0;
          m_ptr  = (g + 1) % N_CH;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N_CH; k++) begin
      if (rd_now[k] && q[k].size() != 0) void'(q[k].pop_front());
    end
    drive_fifo();
  endtask

  function automatic bit pending();
    bit p;
    p = out_valid || busy;
    for (int k = 0; k < N_CH; k++) p = p || (q[k].size() != 0);
    return p;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  initial begin
    int base, cs, c;
    logic [N_CH-1:0] prev, r;
    int gch [$];
    int glen[$];

    model_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    fifo_empty = '1;
    fifo_data  = '0;
    clear_all();

    // Reset held with activity on the inputs: everything stays at zero.
    push(1, 8'h11);
    push(3, 8'h33);
    for (int i = 0; i < 4; i++) begin
      out_ready = i[0];
      cycle();
    end
    check("rst_valid", out_valid, 0);
    check("rst_rd_en", rd_en, 0);
    clear_all();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();
    check("idle_busy", busy, 0);

    // Single channel: ch2 holds A1..A3.
    base = rd_log.size();
    cs   = cons_dat.size();
    push(2, 8'hA1);
    push(2, 8'hA2);
    push(2, 8'hA3);
    repeat (6) cycle();
    for (int i = 0; i < 6; i++) check("single_rd_seq", rd_log[base+i], exp_single[i]);
    check("single_count", cons_dat.size() - cs, 3);
    for (int i = 0; i < 3; i++) begin
      if (cs + i < cons_dat.size()) begin
        check("single_data", cons_dat[cs+i], 8'hA1 + i);
        check("single_ch", cons_ch[cs+i], 2);
      end
    end

    // Pointer sits at 3 after ch2: ch3 must win over ch0.
    base = rd_log.size();
    push(0, 8'h10);
    push(3, 8'h30);
    repeat (6) cycle();
    for (int i = 0; i < 6; i++) check("ptr_wrap_rd_seq", rd_log[base+i], exp_pin[i]);

    // Burst limit: 6 words on ch0 -> 4 pops, idle, 2 pops.
    base = rd_log.size();
    for (int i = 0; i < 6; i++) push(0, 8'h40 + i);
    repeat (10) cycle();
    for (int i = 0; i < 10; i++) check("burst_rd_seq", rd_log[base+i], exp_burst[i]);

    // Backpressure mid-burst on ch1.
    for (int i = 0; i < 6; i++) push(1, 8'h50 + i);
    repeat (3) cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_rd_held", rd_log[rd_log.size()-1], 0);
      check("bp_data_held", out_data, 8'h51);
      check("bp_ch_held", out_ch, 1);
    end
    drain("bp_drain_timeout", 40);
    check("bp_all_delivered", exp_w[1].size(), 0);

    // Asynchronous reset in the middle of a ch2 burst.
    for (int i = 0; i < 4; i++) push(2, 8'h60 + i);
    repeat (3) cycle();
    check("pre_arst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_ch", out_ch, 0);
    check("arst_rd_en", rd_en, 0);
    check("arst_busy", busy, 0);
    clear_all();
    repeat (2) cycle();
    rst_n = 1'b1;

    // Round robin from ch0 after reset: 8 words on every channel.
    base = rd_log.size();
    for (int k = 0; k < N_CH; k++)
      for (int i = 0; i < 8; i++) push(k, WIDTH'($urandom));
    drain("rr_drain_timeout", 150);
    prev = '0;
    for (int i = base; i < rd_log.size(); i++) begin
      r = rd_log[i];
      if (r != 0) begin
        c = 0;
        for (int k = 0; k < N_CH; k++) if (r[k]) c = k;
        if (prev == 0) begin
          gch.push_back(c);
          glen.push_back(1);
        end else begin
          glen[glen.size()-1] = glen[glen.size()-1] + 1;
        end
      end
      prev = r;
    end
    check("rr_grant_count", gch.size(), 8);
    for (int i = 0; i < 8 && i < gch.size(); i++) begin
      check("rr_grant_order", gch[i], i % N_CH);
      check("rr_burst_len", glen[i], MAX_BURST);
    end

    // Random traffic with random backpressure.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        c = $urandom_range(0, N_CH - 1);
        if (q[c].size() < 10) push(c, WIDTH'($urandom));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("rand_drain_timeout", 400);
    for (int k = 0; k < N_CH; k++) check("rand_all_delivered", exp_w[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
